// File: rtl/lightbike_move_arbiter.sv
// Game-step pacer and single-port board RAM arbiter for two lightbike move engines.
// Each step latches move requests and serves them round-robin as read-check-write.
module lightbike_move_arbiter #(
    parameter int TICK_DIV = 32,
    parameter int ADDR_W   = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic              mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [1:0]        ack,
    output logic [1:0]        collide,
    output logic              step,
    output logic [5:0]        tick_count
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITE,
        ACK
    } state_t;

    localparam logic [5:0] TICK_LAST = 6'(TICK_DIV - 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        pending;
    logic              ptr;
    logic              cur;
    logic              first;
    logic              tick_due;
    logic              step_fire;
    logic [ADDR_W-1:0] addr_q;

    assign tick_due  = (tick_count == TICK_LAST);
    assign step_fire = (state == IDLE) && tick_due && enable;
    assign step      = step_fire;
    // The pointer's player leads only if it actually requested this step.
    assign first     = req[ptr] ? ptr : !ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (step_fire && (req != 2'b00)) state_nxt = READ;
            READ:    state_nxt = CHECK;
            CHECK:   state_nxt = mem_rdata ? ACK : WRITE;
            WRITE:   state_nxt = ACK;
            ACK:     state_nxt = pending[!cur] ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_rd   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        ack      = 2'b00;
        case (state)
            READ: begin
                mem_rd   = 1'b1;
                mem_addr = cur ? p2_addr : p1_addr;
            end
            WRITE: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
            end
            ACK:     ack[cur] = 1'b1;
            default: ;
        endcase
    end

    // Divider saturates while busy so at most one step is ever owed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_count <= 6'd0;
        end else if (!enable || step_fire) begin
            tick_count <= 6'd0;
        end else if (!tick_due) begin
            tick_count <= tick_count + 6'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= 2'b00;
            ptr     <= 1'b0;
            cur     <= 1'b0;
            addr_q  <= '0;
            collide <= 2'b00;
        end else begin
            if (step_fire) begin
                pending <= req;
                ptr     <= !ptr;
                cur     <= first;
            end
            case (state)
                READ:  addr_q <= cur ? p2_addr : p1_addr;
                CHECK: if (mem_rdata) collide[cur] <= 1'b1;
                ACK: begin
                    pending[cur] <= 1'b0;
                    if (pending[!cur]) cur <= !cur;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lightbike_move_arbiter.sv
// Bench for lightbike_move_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model that expands each step into bus cycles.
module tb_lightbike_move_arbiter;

    localparam int TD = 4;
    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [AW-1:0] p1_addr = '0;
    logic [AW-1:0] p2_addr = '0;
    logic          mem_rdata = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_we;
    logic [1:0]    ack;
    logic [1:0]    collide;
    logic          step;
    logic [5:0]    tick_count;

    lightbike_move_arbiter #(.TICK_DIV(TD), .ADDR_W(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .p1_addr    (p1_addr),
        .p2_addr    (p2_addr),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .ack        (ack),
        .collide    (collide),
        .step       (step),
        .tick_count (tick_count)
    );

    always #5 clock = ~clock;

    // Some cells start occupied (walls) without ever being written.
    function automatic bit pre_occ(logic [AW-1:0] a);
        return (a[2:0] == 3'd5) && (a[AW-1:8] == '0);
    endfunction

    // Board RAM environment: registered read, write data constant 1.
    bit ram [0:4095];
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= 1'b1;
        mem_rdata <= mem_rd ? (ram[mem_addr] | pre_occ(mem_addr)) : 1'b0;
    end

    typedef struct {
        logic          rd;
        logic          we;
        logic [AW-1:0] addr;
        logic [1:0]    ack;
        logic [1:0]    setc;
    } rec_t;

    rec_t       q[$];
    bit         mboard [0:4095];
    int         m_tick = 0;
    bit         m_ptr = 1'b0;
    logic [1:0] m_col = 2'b00;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expand one step into its expected bus cycles, in service order.
    task automatic serve(input logic [1:0] r);
        bit            first;
        bit            p;
        logic [AW-1:0] a;
        rec_t          rc;
        first = r[m_ptr] ? m_ptr : !m_ptr;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first : !first;
            if (r[p]) begin
                a = p ? p2_addr : p1_addr;
                rc = '{rd: 1'b1, we: 1'b0, addr: a, ack: 2'b00, setc: 2'b00};
                q.push_back(rc);
                rc = '{rd: 1'b0, we: 1'b0, addr: '0, ack: 2'b00, setc: 2'b00};
                q.push_back(rc);
                if (mboard[a] || pre_occ(a)) begin
                    rc = '{rd: 1'b0, we: 1'b0, addr: '0, ack: 2'(1 << p), setc: 2'(1 << p)};
                    q.push_back(rc);
                end else begin
                    rc = '{rd: 1'b0, we: 1'b1, addr: a, ack: 2'b00, setc: 2'b00};
                    q.push_back(rc);
                    mboard[a] = 1'b1;
                    rc = '{rd: 1'b0, we: 1'b0, addr: '0, ack: 2'(1 << p), setc: 2'b00};
                    q.push_back(rc);
                end
            end
        end
    endtask

    // One clock: apply inputs, check this cycle's outputs, advance the model over the edge.
    task automatic do_cycle(input bit en, input logic [1:0] rq,
                            input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rec_t r;
        bit   e_step;
        @(negedge clock);
        enable = en;
        req    = rq;
        if (q.size() == 0) begin
            p1_addr = a1;
            p2_addr = a2;
        end
        #1;
        e_step = en && (q.size() == 0) && (m_tick == TD - 1);
        if (q.size() != 0) r = q[0];
        else r = '{rd: 1'b0, we: 1'b0, addr: '0, ack: 2'b00, setc: 2'b00};
        m_col = m_col | r.setc;
        chk("step", 32'(step), 32'(e_step));
        chk("tick_count", 32'(tick_count), 32'(m_tick));
        chk("mem_rd", 32'(mem_rd), 32'(r.rd));
        chk("mem_we", 32'(mem_we), 32'(r.we));
        chk("mem_addr", 32'(mem_addr), 32'(r.addr));
        chk("ack", 32'(ack), 32'(r.ack));
        chk("collide", 32'(collide), 32'(m_col));
        if (q.size() != 0) void'(q.pop_front());
        if (e_step) begin
            serve(rq);
            m_ptr = !m_ptr;
        end
        if (!en || e_step) m_tick = 0;
        else if (m_tick < TD - 1) m_tick = m_tick + 1;
    endtask

    initial begin
        bit found;
        #7;
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_tick", 32'(tick_count), 32'd0);
        chk("reset_bus", {mem_rd, mem_we, 30'(mem_addr)}, 32'd0);
        chk("reset_ack_col", {ack, collide}, 32'd0);
        #5 reset = 1'b1;

        // Pacing with no requests, then enable drop.
        for (int i = 0; i < 12; i++) do_cycle(1'b1, 2'b00, '0, '0);
        for (int i = 0; i < 2; i++)  do_cycle(1'b0, 2'b00, '0, '0);
        for (int i = 0; i < 3; i++)  do_cycle(1'b1, 2'b00, '0, '0);

        // Single move by player1, then quiet.
        for (int i = 0; i < 5; i++)  do_cycle(1'b1, 2'b01, 12'h123, 12'h200);
        for (int i = 0; i < 8; i++)  do_cycle(1'b1, 2'b00, 12'h123, 12'h200);

        // Player2 hits a wall cell; collide must stay set afterwards.
        for (int i = 0; i < 5; i++)  do_cycle(1'b1, 2'b10, 12'h300, 12'h0D5);
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 2'b00, 12'h300, 12'h0D5);

        // Round-robin with distinct cells, then both on the same cell.
        for (int i = 0; i < 30; i++) do_cycle(1'b1, 2'b11, 12'h400 + 12'(i), 12'h500 + 12'(i));
        for (int i = 0; i < 30; i++) do_cycle(1'b1, 2'b11, 12'h600 + 12'(i), 12'h600 + 12'(i));

        // Enable falls mid-service: pending work still completes.
        for (int i = 0; i < 14; i++) do_cycle(1'b1, 2'b00, 12'h700, 12'h701);
        for (int i = 0; i < 4; i++)  do_cycle(1'b1, 2'b11, 12'h710, 12'h711);
        for (int i = 0; i < 12; i++) do_cycle(1'b0, 2'b11, 12'h720, 12'h721);

        // Reset asserted during WRITE.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            do_cycle(1'b1, 2'b01, 12'h5A0 + 12'(i), 12'h000);
            found = (q.size() != 0) && q[0].we;
        end
        chk("reach_write", 32'(found), 32'd1);
        if (found) begin
            @(posedge clock);
            #2;
            chk("pre_reset_we", 32'(mem_we), 32'd1);
            reset = 1'b0;
            #1;
            chk("async_we", 32'(mem_we), 32'd0);
            chk("async_ack", 32'(ack), 32'd0);
            chk("async_collide", 32'(collide), 32'd0);
            chk("async_tick", 32'(tick_count), 32'd0);
            chk("async_step", 32'(step), 32'd0);
            foreach (q[i]) if (q[i].we) mboard[q[i].addr] = 1'b0;
            q.delete();
            m_tick = 0;
            m_ptr  = 1'b0;
            m_col  = 2'b00;
            #1 reset = 1'b1;
        end
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 2'b11, 12'h800 + 12'(i), 12'h900 + 12'(i));

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a1;
            logic [AW-1:0] a2;
            a1 = 12'($urandom_range(0, 255));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 12'($urandom_range(0, 255));
            do_cycle($urandom_range(0, 15) != 0, 2'($urandom), a1, a2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
